reg_file_output_selector: RTL and testbench

- Read side of the 16 x 16-bit byte-addressable register file; mirrors the write-side input decoder's addressing.
- Selects one or two bytes, or one full word, from the flattened 256-bit register bus.
- Forwards same-cycle writes: wen/data from the input decoder take priority over stale register contents.
- Presents the result through a registered valid/ready output stage with back-pressure hold.

---
 rtl/reg_file_output_selector_if.sv | 27 ++
 rtl/reg_file_output_selector.sv | 99 +++++++++
 tb/tb_reg_file_output_selector.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_output_selector_if.sv
// Read-port bundle of the register-file output selector: request, forwarding inputs and registered result.
interface reg_file_output_selector_if #(
    parameter int NUM_REGS  = 16,
    parameter int REG_WIDTH = 16
);
    logic [1:0]                    rd_en;
    logic                          rd_word;
    logic [9:0]                    rd_addr;
    logic [NUM_REGS*REG_WIDTH-1:0] reg_data;
    logic [NUM_REGS*2-1:0]         wen;
    logic [NUM_REGS*REG_WIDTH-1:0] wr_data;
    logic                          out_ready;
    logic                          in_ready;
    logic [REG_WIDTH-1:0]          data_out;
    logic [1:0]                    data_bvalid;
    logic                          data_valid;

    modport master (
        output rd_en, rd_word, rd_addr, reg_data, wen, wr_data, out_ready,
        input  in_ready, data_out, data_bvalid, data_valid
    );

    modport slave (
        input  rd_en, rd_word, rd_addr, reg_data, wen, wr_data, out_ready,
        output in_ready, data_out, data_bvalid, data_valid
    );
endinterface

// File: rtl/reg_file_output_selector.sv
// Byte/word read selector for the 16 x 16-bit register file with same-cycle write forwarding
// and a single registered output slot that holds under back-pressure.
module reg_file_output_selector #(
    parameter int NUM_REGS  = 16,
    parameter int REG_WIDTH = 16
) (
    input logic                        clock,
    input logic                        reset,
    reg_file_output_selector_if.slave  bus
);
    localparam int BUS_W = NUM_REGS * REG_WIDTH;
    localparam int WEN_W = NUM_REGS * 2;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Byte (r, b) lives at bit 8*(2r+b) in both buses; wen uses the same 2r+b index.
    function automatic logic [7:0] fetch_byte(
        input logic [3:0]       r,
        input logic             b,
        input logic [BUS_W-1:0] regs,
        input logic [WEN_W-1:0] wen,
        input logic [BUS_W-1:0] wr
    );
        logic [4:0] idx;
        idx = {r, b};
        if (wen[idx])
            fetch_byte = wr[{idx, 3'b000} +: 8];
        else
            fetch_byte = regs[{idx, 3'b000} +: 8];
    endfunction

    logic [0:0]           state_p1;
    logic [REG_WIDTH-1:0] data_p1;
    logic [1:0]           bvalid_p1;

    logic                 vld_p1;
    logic                 in_ready;
    logic                 accept;
    logic                 word_mode;
    logic [3:0]           lo_reg;
    logic                 lo_sel;
    logic [3:0]           hi_reg;
    logic                 hi_sel;
    logic [REG_WIDTH-1:0] data_p0;
    logic [1:0]           bvalid_p0;

    assign vld_p1    = (state_p1 == ST_FULL);
    assign in_ready  = !vld_p1 || bus.out_ready;
    assign accept    = (bus.rd_en != 2'b00) && in_ready;
    assign word_mode = bus.rd_word && (bus.rd_en == 2'b11);

    assign lo_reg = bus.rd_addr[3:0];
    assign lo_sel = bus.rd_addr[4];
    assign hi_reg = bus.rd_addr[8:5];
    assign hi_sel = bus.rd_addr[9];

    // ---- stage p0: byte selection and forwarding ----
    always_comb begin
        data_p0   = '0;
        bvalid_p0 = 2'b00;
        if (word_mode) begin
            data_p0[15:8] = fetch_byte(lo_reg, 1'b1, bus.reg_data, bus.wen, bus.wr_data);
            data_p0[7:0]  = fetch_byte(lo_reg, 1'b0, bus.reg_data, bus.wen, bus.wr_data);
            bvalid_p0     = 2'b11;
        end else begin
            if (bus.rd_en[0]) begin
                data_p0[7:0] = fetch_byte(lo_reg, lo_sel, bus.reg_data, bus.wen, bus.wr_data);
                bvalid_p0[0] = 1'b1;
            end
            if (bus.rd_en[1]) begin
                data_p0[15:8] = fetch_byte(hi_reg, hi_sel, bus.reg_data, bus.wen, bus.wr_data);
                bvalid_p0[1]  = 1'b1;
            end
        end
    end

    // ---- stage p1: output slot (load / drain / hold) ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_p1  <= ST_EMPTY;
            data_p1   <= '0;
            bvalid_p1 <= 2'b00;
        end else if (accept) begin
            state_p1  <= ST_FULL;
            data_p1   <= data_p0;
            bvalid_p1 <= bvalid_p0;
        end else if (vld_p1 && bus.out_ready) begin
            state_p1  <= ST_EMPTY;
            data_p1   <= '0;
            bvalid_p1 <= 2'b00;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.data_out    = data_p1;
    assign bus.data_bvalid = bvalid_p1;
    assign bus.data_valid  = vld_p1;
endmodule

// File: tb/tb_reg_file_output_selector.sv
// Self-checking bench for reg_file_output_selector: directed vector table, hand sequences and a random run against a reference model.
module tb_reg_file_output_selector;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    reg_file_output_selector_if bus ();

    reg_file_output_selector dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic        m_valid = 1'b0;
    logic [15:0] m_data  = 16'h0000;
    logic [1:0]  m_bv    = 2'b00;

    typedef struct {
        logic [1:0]  rd_en;
        logic        rd_word;
        logic [9:0]  rd_addr;
        int          ra;
        logic [15:0] va;
        int          rb;
        logic [15:0] vb;
        logic [31:0] wen;
        int          wr_r;
        logic [15:0] wr_v;
        logic [15:0] exp_data;
        logic [1:0]  exp_bv;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int r, input int b);
        logic [15:0] cur;
        logic [15:0] pend;
        cur  = bus.reg_data[16*r +: 16];
        pend = bus.wr_data[16*r +: 16];
        if (bus.wen[2*r+b]) return pend[8*b +: 8];
        return cur[8*b +: 8];
    endfunction

    // Advance the reference by one clock using the inputs present just before the edge.
    task automatic model_edge();
        logic        rdy;
        logic [15:0] d;
        logic [1:0]  bv;
        int lo_r, hi_r;
        rdy  = !m_valid || bus.out_ready;
        lo_r = int'(bus.rd_addr[3:0]);
        hi_r = int'(bus.rd_addr[8:5]);
        d = 16'h0000;
        bv = 2'b00;
        if (bus.rd_word && bus.rd_en == 2'b11) begin
            d  = {ref_byte(lo_r, 1), ref_byte(lo_r, 0)};
            bv = 2'b11;
        end else begin
            if (bus.rd_en[0]) begin d[7:0]  = ref_byte(lo_r, int'(bus.rd_addr[4])); bv[0] = 1'b1; end
            if (bus.rd_en[1]) begin d[15:8] = ref_byte(hi_r, int'(bus.rd_addr[9])); bv[1] = 1'b1; end
        end
        if (reset) begin
            m_valid = 1'b0; m_data = 16'h0000; m_bv = 2'b00;
        end else if (bus.rd_en != 2'b00 && rdy) begin
            m_valid = 1'b1; m_data = d; m_bv = bv;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0; m_data = 16'h0000; m_bv = 2'b00;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_buses();
        for (int i = 0; i < 8; i++) begin
            bus.reg_data[32*i +: 32] = $urandom();
            bus.wr_data[32*i +: 32]  = $urandom();
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [15:0] d, input logic [1:0] bv);
        chk({name, "_valid"}, {31'd0, bus.data_valid}, {31'd0, v});
        chk({name, "_data"}, {16'd0, bus.data_out}, {16'd0, d});
        chk({name, "_bvalid"}, {30'd0, bus.data_bvalid}, {30'd0, bv});
    endtask

    task automatic lane_req(input logic [1:0] en, input logic [9:0] addr);
        bus.rd_en   = en;
        bus.rd_word = 1'b0;
        bus.rd_addr = addr;
    endtask

    initial begin
        vecs[0] = '{2'b01, 1'b0, 10'h015, 5,  16'hA1B2, 5,  16'hA1B2, 32'h0,        0, 16'h0000, 16'h00A1, 2'b01};
        vecs[1] = '{2'b11, 1'b0, 10'h123, 3,  16'h1234, 9,  16'h5678, 32'h0004_0000, 9, 16'h00EE, 16'hEE34, 2'b11};
        vecs[2] = '{2'b11, 1'b1, 10'h2AF, 15, 16'hCAFE, 15, 16'hCAFE, 32'h0,        0, 16'h0000, 16'hCAFE, 2'b11};
        vecs[3] = '{2'b10, 1'b0, 10'h0A0, 5,  16'hA1B2, 5,  16'hA1B2, 32'h0,        0, 16'h0000, 16'hB200, 2'b10};
        vecs[4] = '{2'b11, 1'b1, 10'h007, 7,  16'hBEEF, 7,  16'hBEEF, 32'h0000_8000, 7, 16'h1200, 16'h12EF, 2'b11};
        vecs[5] = '{2'b01, 1'b1, 10'h012, 2,  16'h3344, 2,  16'h3344, 32'h0,        0, 16'h0000, 16'h0033, 2'b01};
        vecs[6] = '{2'b11, 1'b0, 10'h084, 4,  16'h9A78, 4,  16'h9A78, 32'h0,        0, 16'h0000, 16'h7878, 2'b11};

        bus.rd_en = 2'b11; bus.rd_word = 1'b0; bus.rd_addr = 10'h015;
        bus.reg_data = '0; bus.wen = '0; bus.wr_data = '0; bus.out_ready = 1'b1;

        // Reset with a live request must leave the slot empty.
        reset = 1'b1;
        cycle();
        cycle();
        check_out("reset", 1'b0, 16'h0000, 2'b00);
        reset = 1'b0;
        bus.rd_en = 2'b00;
        #1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        foreach (vecs[i]) begin
            randomize_buses();
            bus.wen = '0;
            bus.reg_data[16*vecs[i].ra +: 16] = vecs[i].va;
            bus.reg_data[16*vecs[i].rb +: 16] = vecs[i].vb;
            bus.wen = vecs[i].wen;
            if (vecs[i].wen != 0) bus.wr_data[16*vecs[i].wr_r +: 16] = vecs[i].wr_v;
            bus.rd_en = vecs[i].rd_en; bus.rd_word = vecs[i].rd_word; bus.rd_addr = vecs[i].rd_addr;
            bus.out_ready = 1'b1;
            cycle();
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_data, vecs[i].exp_bv);
            bus.rd_en = 2'b00; bus.rd_word = 1'b0;
            cycle();
            check_out($sformatf("vec%0d_drain", i), 1'b0, 16'h0000, 2'b00);
        end

        // Back-pressure: result frozen while request and register contents move.
        bus.wen = '0;
        bus.reg_data[16*5 +: 16] = 16'hA1B2;
        lane_req(2'b01, 10'h015);
        bus.out_ready = 1'b1;
        cycle();
        check_out("bp_load", 1'b1, 16'h00A1, 2'b01);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lane_req(2'b11, 10'h005 + 10'(k));
            bus.reg_data[16*5 +: 16] = 16'h5566 + 16'(k);
            #1;
            chk($sformatf("bp_in_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
            cycle();
            check_out($sformatf("bp_hold%0d", k), 1'b1, 16'h00A1, 2'b01);
        end
        bus.reg_data[16*5 +: 16] = 16'h5566;
        lane_req(2'b01, 10'h005);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        cycle();
        check_out("bp_release", 1'b1, 16'h0066, 2'b01);

        // Back-to-back: four requests, four consecutive results, then drain.
        bus.reg_data[16*0 +: 16] = 16'h1100;
        bus.reg_data[16*1 +: 16] = 16'h3322;
        bus.reg_data[16*2 +: 16] = 16'h5544;
        bus.reg_data[16*3 +: 16] = 16'h7766;
        for (int k = 0; k < 4; k++) begin
            bus.rd_en = 2'b11; bus.rd_word = 1'b1; bus.rd_addr = 10'(k);
            cycle();
            check_out($sformatf("b2b%0d", k), 1'b1, 16'h1100 + 16'(k) * 16'h2222, 2'b11);
        end
        bus.rd_en = 2'b00; bus.rd_word = 1'b0;
        cycle();
        check_out("b2b_drain", 1'b0, 16'h0000, 2'b00);

        // Reset while full, with the consumer stalled and a request pending.
        lane_req(2'b01, 10'h015);
        bus.reg_data[16*5 +: 16] = 16'hA1B2;
        cycle();
        check_out("rst_full_load", 1'b1, 16'h00A1, 2'b01);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        cycle();
        check_out("rst_full", 1'b0, 16'h0000, 2'b00);
        reset = 1'b0;
        bus.rd_en = 2'b00;
        bus.out_ready = 1'b1;
        cycle();

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            randomize_buses();
            bus.wen       = $urandom() & $urandom();
            bus.rd_en     = 2'($urandom_range(0, 3));
            bus.rd_word   = 1'($urandom_range(0, 1));
            bus.rd_addr   = 10'($urandom());
            bus.out_ready = ($urandom_range(0, 3) != 0);
            reset         = ($urandom_range(0, 31) == 0);
            #1;
            chk("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
            cycle();
            check_out("rnd", m_valid, m_data, m_bv);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
